// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode, ALU encoding and sequencer state definitions
package risc_pkg;

  // Instruction opcodes (IR[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation encodings, shared with the ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_FETCH_OP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  // Coarse instruction classes; undefined opcodes decode as CLS_NOP
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_LDI  = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_JZ   = 3'd4,
    CLS_HALT = 3'd5
  } op_class_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction register decode
module instr_decoder
  import risc_pkg::*;
(
  input  logic [7:0] ir,
  output op_class_t  op_class,
  output logic       needs_operand,
  output logic [1:0] alu_op,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic       illegal
);

  logic [3:0] opcode;

  assign opcode = ir[7:4];
  assign rd     = ir[3:2];
  assign rs     = ir[1:0];

  // Map opcode to class, operand need and ALU function
  always_comb begin
    op_class      = CLS_NOP;
    needs_operand = 1'b0;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    case (opcode)
      OP_NOP:  op_class = CLS_NOP;
      OP_ADD:  begin op_class = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_LDI:  begin op_class = CLS_LDI; needs_operand = 1'b1; end
      OP_JMP:  begin op_class = CLS_JMP; needs_operand = 1'b1; end
      OP_JZ:   begin op_class = CLS_JZ;  needs_operand = 1'b1; end
      OP_HALT: op_class = CLS_HALT;
      default: begin op_class = CLS_NOP; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer for the 8-bit RISC core
module control_unit
  import risc_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic [1:0] alu_op,
  input  logic       alu_zero,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic [1:0] rf_wa,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic [7:0] imm,
  output logic       halted,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       z_q, z_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  op_class_t  dec_class;
  logic       dec_needs_op;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic       dec_illegal;
  logic       in_exec;

  instr_decoder u_decoder (
    .ir            (ir_q),
    .op_class      (dec_class),
    .needs_operand (dec_needs_op),
    .alu_op        (dec_alu_op),
    .rd            (dec_rd),
    .rs            (dec_rs),
    .illegal       (dec_illegal)
  );

  // Next-state and register update logic for the sequencer
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    z_d       = z_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_class == CLS_HALT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (dec_class == CLS_NOP) begin
          state_d = ST_FETCH;
          if (dec_illegal) illegal_d = 1'b1;
        end else if (dec_needs_op) begin
          state_d = ST_FETCH_OP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_FETCH_OP: begin
        imm_d   = imem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (dec_class)
          CLS_ALU: z_d  = alu_zero;
          CLS_JMP: pc_d = imm_q;
          CLS_JZ:  if (z_q) pc_d = imm_q;
          default: ;
        endcase
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Sequencer registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= 8'h00;
      imm_q     <= 8'h00;
      z_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      z_q       <= z_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath controls are live only in EXEC so rf_we is a single-cycle pulse
  always_comb begin
    in_exec = (state_q == ST_EXEC);
    rf_we   = in_exec && ((dec_class == CLS_ALU) || (dec_class == CLS_LDI));
    rf_wsel = in_exec && (dec_class == CLS_LDI);
    alu_op  = (in_exec && (dec_class == CLS_ALU)) ? dec_alu_op : ALU_ADD;
  end

  assign imem_addr = pc_q;
  assign rf_ra     = dec_rd;
  assign rf_rb     = dec_rs;
  assign rf_wa     = dec_rd;
  assign imm       = imm_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against an instruction-level model
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [1:0] alu_op;
  logic       alu_zero;
  logic [1:0] rf_ra;
  logic [1:0] rf_rb;
  logic [1:0] rf_wa;
  logic       rf_we;
  logic       rf_wsel;
  logic [7:0] imm;
  logic       halted;
  logic       illegal;

  logic [7:0] mem [256];

  int checks;
  int errors;
  int force_z;

  // Instruction-level reference state
  logic [7:0] m_pc;
  logic       m_z;
  logic       m_illegal;

  control_unit #(.PC_RESET(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .alu_op     (alu_op),
    .alu_zero   (alu_zero),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_wa      (rf_wa),
    .rf_we      (rf_we),
    .rf_wsel    (rf_wsel),
    .imm        (imm),
    .halted     (halted),
    .illegal    (illegal)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Apply reset, check reset values, release on a falling edge so the next rising edge is the first fetch
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_wsel", rf_wsel, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_imm", imm, 8'h00);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    m_pc      = 8'h00;
    m_z       = 1'b0;
    m_illegal = 1'b0;
  endtask

  // Run one instruction at the model PC, checking every cycle; returns 1 if it was HALT
  task automatic run_instr(output bit was_halt);
    logic [7:0] ib, opnd, npc;
    logic [3:0] opc;
    logic [1:0] aop;
    logic       nz, zv;
    int         n;
    bit         wr, wsel, is_alu, ill;
    ib   = mem[m_pc];
    opnd = mem[m_pc + 8'd1];
    opc  = ib[7:4];
    n = 2; wr = 0; wsel = 0; is_alu = 0; ill = 0; aop = 2'b00; was_halt = 0;
    nz = m_z;
    if (opc >= 4'h1 && opc <= 4'h4) begin
      n = 3; wr = 1; is_alu = 1; aop = 2'(opc - 4'h1);
    end else if (opc >= 4'h5 && opc <= 4'h7) begin
      n = 4; wr = (opc == 4'h5); wsel = (opc == 4'h5);
    end else if (opc == 4'hF) begin
      was_halt = 1;
    end else if (opc != 4'h0) begin
      ill = 1;
    end
    npc = m_pc + 8'(n == 4 ? 2 : 1);
    if (opc == 4'h6) npc = opnd;
    if (opc == 4'h7 && m_z) npc = opnd;
    for (int c = 0; c < n; c++) begin
      zv = (force_z < 0) ? 1'($urandom_range(0, 1)) : 1'(force_z);
      alu_zero = zv;
      #1;
      if (c == 0) check("imem_addr_fetch", imem_addr, m_pc);
      check("rf_we", rf_we, (wr && c == n - 1));
      if (c == n - 1 && wr) begin
        check("rf_wa", rf_wa, ib[3:2]);
        check("rf_wsel", rf_wsel, wsel);
        check("alu_op_exec", alu_op, aop);
        if (is_alu) nz = zv;
      end else begin
        check("alu_op_idle", alu_op, 0);
        check("rf_wsel_idle", rf_wsel, 0);
      end
      if (c >= 1) begin
        check("rf_ra", rf_ra, ib[3:2]);
        check("rf_rb", rf_rb, ib[1:0]);
      end
      if (c == 3 && n == 4) check("imm", imm, opnd);
      check("halted_run", halted, 0);
      check("illegal_run", illegal, m_illegal);
      @(negedge clk);
    end
    m_pc      = npc;
    m_z       = nz;
    m_illegal = m_illegal | ill;
  endtask

  task automatic run_n(input int count);
    bit h;
    for (int i = 0; i < count; i++) run_instr(h);
  endtask

  initial begin
    bit h;
    checks   = 0;
    errors   = 0;
    force_z  = -1;
    alu_zero = 1'b0;
    rst_n    = 1'b0;
    clear_mem();

    // LDI R1,05; LDI R2,05; SUB R1,R2 with zero; JZ 20 taken
    mem[0] = 8'h54; mem[1] = 8'h05;
    mem[2] = 8'h58; mem[3] = 8'h05;
    mem[4] = 8'h26;
    mem[5] = 8'h70; mem[6] = 8'h20;
    force_z = 1;
    do_reset();
    run_n(4);
    #1 check("jz_taken_addr", imem_addr, 8'h20);

    // JMP 0F; ADD without zero; JZ 20 at 10 not taken
    clear_mem();
    mem[8'h00] = 8'h60; mem[8'h01] = 8'h0F;
    mem[8'h0F] = 8'h11;
    mem[8'h10] = 8'h70; mem[8'h11] = 8'h20;
    force_z = 0;
    do_reset();
    run_n(3);
    #1 check("jz_not_taken_addr", imem_addr, 8'h12);

    // JMP FE through PC wrap
    clear_mem();
    mem[8'h00] = 8'h60; mem[8'h01] = 8'hFE;
    do_reset();
    run_n(3);
    #1 check("pc_wrap_addr", imem_addr, 8'h00);

    // Reset during EXEC of ADD aborts the write and leaves Z at 0
    clear_mem();
    mem[8'h00] = 8'h11;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    alu_zero = 1'b1;
    #1 check("exec_rf_we_before_rst", rf_we, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rf_we", rf_we, 0);
    check("rst_mid_pc", imem_addr, 8'h00);
    @(negedge clk);
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h20;
    rst_n = 1'b1;
    m_pc = 8'h00; m_z = 1'b0; m_illegal = 1'b0;
    run_n(1);
    #1 check("rst_mid_z_kept_zero", imem_addr, 8'h02);

    // Undefined opcode: sticky illegal, next instruction normal
    clear_mem();
    mem[8'h00] = 8'h8B;
    mem[8'h01] = 8'h5C; mem[8'h02] = 8'hAB;
    mem[8'h03] = 8'h1D;
    force_z = -1;
    do_reset();
    run_n(1);
    #1 check("illegal_set", illegal, 1);
    check("illegal_pc", imem_addr, 8'h01);
    run_n(3);
    #1 check("illegal_sticky", illegal, 1);

    // HALT: frozen for 100 cycles, reset clears it
    clear_mem();
    mem[8'h00] = 8'h00;
    mem[8'h01] = 8'hF0;
    do_reset();
    run_n(1);
    run_instr(h);
    for (int c = 0; c < 100; c++) begin
      alu_zero = 1'($urandom_range(0, 1));
      #1;
      check("halt_halted", halted, 1);
      check("halt_rf_we", rf_we, 0);
      check("halt_addr", imem_addr, 8'h02);
      @(negedge clk);
    end
    do_reset();
    #1 check("halt_cleared", halted, 0);

    // Random programs without HALT bytes against the model
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom_range(0, 255));
        if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'($urandom_range(0, 14));
      end
      force_z = -1;
      do_reset();
      run_n(150);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit RISC core. It owns the PC, instruction register, operand register and zero flag. It fetches from instruction memory, decodes, and generates `alu_op` and register-file controls for the ALU and register file. It also consumes the ALU `zero` output to resolve conditional branches. It is the producer side of the ALU control interface.

## Interface
Parameters:
- `PC_RESET`, 8'h00, PC value after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  8  instruction memory address; equals PC.
- `imem_rdata`  in  8  instruction/operand byte; combinational read of `imem_addr`.
- `alu_op`  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_zero`  in  1  ALU zero output for the current operands.
- `rf_ra`  out  2  register file read port A (rd field).
- `rf_rb`  out  2  register file read port B (rs field).
- `rf_wa`  out  2  register file write address.
- `rf_we`  out  1  register file write enable.
- `rf_wsel`  out  1  write data select: 0 = ALU result, 1 = `imm`.
- `imm`  out  8  latched operand byte.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  sticky flag; set on an undefined opcode.

## Operation
- Instruction byte fields:
  - `[7:4]` opcode.
  - `[3:2]` rd.
  - `[1:0]` rs.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd <= rd op rs.
  - 5 LDI: rd <= next byte.
  - 6 JMP: PC <= next byte.
  - 7 JZ: if Z, PC <= next byte.
  - F HALT.
  - 8–E undefined: set `illegal` and execute as NOP.
- States: FETCH, DECODE, FETCH_OP, EXEC, HALT.
- FETCH: IR <= `imem_rdata`, PC <= PC+1 → DECODE.
- DECODE transitions:
  - NOP or undefined → FETCH.
  - HALT → HALT.
  - ALU ops → EXEC.
  - LDI, JMP, JZ → FETCH_OP.
- FETCH_OP: `imm` <= `imem_rdata`, PC <= PC+1 → EXEC.
- EXEC behaviour:
  - ALU ops: drive `alu_op` from opcode, `rf_we`=1, `rf_wsel`=0, `rf_wa`=rd; Z <= `alu_zero`.
  - LDI: `rf_we`=1, `rf_wsel`=1, `rf_wa`=rd.
  - JMP: PC <= `imm`.
  - JZ: PC <= `imm` only if Z=1; Z unchanged.
  - All paths → FETCH.
- HALT: absorbing state; only reset exits.
- Z updates only in EXEC of ALU ops.
- `rf_ra`/`rf_rb` always reflect IR[3:2]/IR[1:0].
- Outside EXEC, `rf_we`=0, `rf_wsel`=0 and `alu_op`=00.
- PC arithmetic is 8-bit modulo: FF+1 = 00.

## Timing
- Reset (async, immediate) values:
  - state FETCH, PC=`PC_RESET`, IR=00, `imm`=00, Z=0.
  - `rf_we`=0, `rf_wsel`=0, `alu_op`=00, `halted`=0, `illegal`=0.
- Reset asserted mid-instruction aborts it: no register-file write, and PC is not updated.
- First FETCH occurs on the first rising edge after `rst_n` deasserts.
- Cycles per instruction:
  - NOP/undefined: 2.
  - ALU ops: 3.
  - LDI/JMP/JZ: 4.
  - HALT: reaches HALT after 2.
- `rf_we` is a single-cycle pulse, combinational from state and IR. The register file writes on the rising edge that ends EXEC.
- Z is sampled on that same edge, from `alu_zero` of the operation being written.
- `imem_addr` is registered (PC). Jump targets appear on `imem_addr` the cycle after EXEC.
- `illegal` sets on the DECODE→FETCH edge and clears only on reset.

## Structure
- Shared package `risc_pkg`:
  - opcode constants.
  - ALU op encodings (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`).
  - state enum.
- This encoding set is shared with the ALU.
- Sub-module `instr_decoder`: combinational IR → {opcode class, needs_operand, alu_op, rd, rs, illegal}.
- The sequencer FSM and registers stay in `control_unit`.

## Test plan
- Run LDI R1,05; LDI R2,05; SUB R1,R2 with `alu_zero`=1 in EXEC.
  - Required: `alu_op`=01, `rf_wa`=1, `rf_we` pulses 1 cycle.
  - Then JZ 20 → `imem_addr`=20 after 4 cycles.
- Run ADD with `alu_zero`=0, then JZ 20 at address 10.
  - Required: branch not taken; next `imem_addr`=12.
- Run JMP FE with NOP at FE and FF.
  - Required: `imem_addr` sequence FE, FF, 00.
- Drop `rst_n` during EXEC of an ADD.
  - Required: `rf_we` falls to 0 immediately, PC=00, Z unchanged at 0.
  - After release, fetch resumes from 00.
- Execute opcode 8x.
  - Required: `illegal`=1 and sticky; no write; PC advances by 1; next instruction executes normally.
- Execute F0.
  - Required: `halted`=1 from the cycle after DECODE; `imem_addr` frozen; `rf_we` held 0 for 100 cycles; reset clears `halted`.
